data_memory_be: RTL and testbench
=================================

# data_memory_be

Byte-addressed, byte-enabled data memory for the MIPS datapath's MEM stage. Supports byte, halfword and word loads and stores, with sign or zero extension on loads, and detects misaligned accesses. Read latency is one registered cycle. A post-reset clear sequencer zeroes the array so simulation and synthesis start from a known state. It replaces the word-only data memory in the CPU and generalises word width and depth.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8, power of two, at least 16
- ADDR_WIDTH, 12, byte-address width; depth WORDS = 2^(ADDR_WIDTH - log2(DATA_WIDTH/8))
- INIT_CLEAR, 1, 1 = zero every word after reset; 0 = skip the clear sequence
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  access request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = store, 0 = load (active-high)
- req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word (32b), 3 = dword (64b only)
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified (low bytes are used)
- rsp_valid  out  1  response for the request accepted last cycle
- rsp_rdata  out  DATA_WIDTH  load data, extended and right-justified; 0 for stores and errors
- rsp_err  out  1  request was misaligned or had an illegal size; the store was suppressed

## Operation
- FSM states:
  - CLEAR: writes 0 to word clr_ptr and increments it. Leaves for READY after writing word WORDS-1.
  - READY: serves requests.
- rst moves the FSM to CLEAR (INIT_CLEAR=1) or READY (INIT_CLEAR=0). rst also resets clr_ptr to 0.
- req_ready = (state == READY) and not rst. Requests are ignored while req_ready is 0.
- A request is accepted when req_valid && req_ready.
- Let BYTES = DATA_WIDTH/8, word index = addr >> log2(BYTES) and lane = addr[log2(BYTES)-1:0].
- Illegal size: req_size > log2(BYTES).
- Misaligned: lane is not a multiple of 2^req_size.
- If the request is illegal or misaligned, no array write occurs, and rsp_err=1 with rsp_rdata=0.
- Store: byte lanes lane .. lane+2^size-1 are written from req_wdata bytes 0 .. 2^size-1. All other lanes are unchanged.
- Load: read the word and shift it right by lane*8. Mask to 2^size bytes, then sign-extend from the top bit of the access or zero-extend, according to req_unsigned.
- Exactly one access per cycle, so there are no port conflicts.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 during rst.
- After rst falls, req_ready rises:
  - WORDS cycles later when INIT_CLEAR=1;
  - on the first cycle when INIT_CLEAR=0.
- Every accepted request (load, store or error) produces rsp_valid=1 exactly one cycle later, for one cycle.
- Throughput is one request per cycle.
- Load-after-store to the same word in back-to-back cycles returns the newly stored bytes. The write commits at the accept edge.
- rsp_rdata and rsp_err are held until the next response. Both are valid only while rsp_valid=1.
- rst asserted mid-stream: any pending response is dropped (rsp_valid=0 next cycle) and the clear sequence restarts from word 0.
- clr_ptr wraps exactly at WORDS-1. No out-of-range writes.

## Structure
- Package data_memory_pkg holds:
  - size codes SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3;
  - the FSM state enum (ST_CLEAR, ST_READY);
  - a function computing the lane mask from size and lane.
- Sub-module data_memory_be_extend: combinational shift, mask and sign/zero extension of the read word. Reused by the CPU for unaligned-load emulation.
- The array is one reg vector per word with a per-byte write loop, so it infers as byte-enable BRAM.

## Test plan
- Reset with INIT_CLEAR=1, ADDR_WIDTH=6 (16 words) -> req_ready low for 16 cycles, then high; a load of address 0x3C returns 0.
- sw 0x80FF7F01 to address 0x10, then lb 0x10 / lb 0x11 / lbu 0x12 / lh 0x12 / lhu 0x12 / lw 0x10 -> responses 0x00000001, 0x0000007F, 0x000000FF, 0xFFFF80FF, 0x000080FF, 0x80FF7F01.
- With word 0x20 = 0x11223344: sb 0xAA to address 0x21, then sh 0xBEEF to address 0x22 -> lw 0x20 returns 0xBEEFAA44.
- sh to address 0x05 and sw to address 0x06 -> rsp_err=1, rsp_rdata=0; a following lw 0x04 shows the word unchanged.
- req_size=3 with DATA_WIDTH=32 -> rsp_err=1, no write. With DATA_WIDTH=64, sd/ld to address 0x08 round-trips 0x0123456789ABCDEF.
- Back-to-back stream of a store then an immediate load to the same word -> load returns the new data. Assert rst while a response is pending -> rsp_valid=0 next cycle, and the clear sequence restarts.

Source files
------------

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared size codes, FSM state type and byte-lane mask helper for data_memory_be
package data_memory_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Widest word supported is 128 bits, so lane masks never need more than 16 bits.
  localparam int MAX_LANES = 16;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size, input logic [3:0] lane);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_LANES; b++)
      if (b < (1 << size)) m[b] = 1'b1;
    return m << lane;
  endfunction

endpackage

// File: rtl/data_memory_be_extend.sv
// rtl/data_memory_be_extend.sv - aligns a read word to its byte lane, masks to access size, sign/zero extends
module data_memory_be_extend
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [LANE_W-1:0]     lane,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = $clog2(DATA_WIDTH);
  // Sign-bit positions clamp to the word's MSB for sizes wider than the word.
  localparam logic [IW-1:0] TOP_B = IW'(7);
  localparam logic [IW-1:0] TOP_H = IW'(15);
  localparam logic [IW-1:0] TOP_W = IW'((DATA_WIDTH >= 32) ? 31 : DATA_WIDTH - 1);
  localparam logic [IW-1:0] TOP_D = IW'((DATA_WIDTH >= 64) ? 63 : DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;
  logic [IW-1:0]         top;
  logic                  sign;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    mask    = '0;
    for (int b = 0; b < BYTES; b++)
      if (b < (1 << size)) mask[b*8 +: 8] = 8'hFF;
    case (size)
      SZ_BYTE: top = TOP_B;
      SZ_HALF: top = TOP_H;
      SZ_WORD: top = TOP_W;
      default: top = TOP_D;
    endcase
    sign = shifted[top] & ~is_unsigned;
    data = (shifted & mask) | (sign ? ~mask : '0);
  end

endmodule

// File: rtl/data_memory_be.sv
// rtl/data_memory_be.sv - byte-enabled data memory with sized loads/stores, misalign detection and post-reset clear
module data_memory_be
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int LANE_W  = $clog2(BYTES);
  localparam int WORD_AW = ADDR_WIDTH - LANE_W;
  localparam int WORDS   = 1 << WORD_AW;

  state_t                state;
  logic [WORD_AW-1:0]    clr_ptr;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rd_word;

  logic [WORD_AW-1:0]    word_idx;
  logic [LANE_W-1:0]     lane, lane_q;
  logic [1:0]            size_q;
  logic                  uns_q, ld_ok;
  logic                  accept, illegal, misaligned, err, wr_en, clr_we;
  logic [3:0]            align_mask;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] wdata_sh, ext_data;

  assign req_ready  = (state == ST_READY) && !rst;
  assign accept     = req_valid && req_ready;
  assign word_idx   = req_addr[ADDR_WIDTH-1:LANE_W];
  assign lane       = req_addr[LANE_W-1:0];
  assign illegal    = int'(req_size) > LANE_W;
  assign align_mask = 4'((5'd1 << req_size) - 5'd1);
  assign misaligned = (4'(lane) & align_mask) != 4'd0;
  assign err        = illegal || misaligned;
  assign wr_en      = accept && req_we && !err;
  assign clr_we     = (state == ST_CLEAR) && !rst;
  assign be         = BYTES'(lane_mask(req_size, 4'(lane)));
  assign wdata_sh   = req_wdata << {lane, 3'b000};

  // Single write port shared by the clear sequencer and stores; the two never overlap by state.
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_ptr] <= '0;
    else if (wr_en)
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
    if (accept)
      rd_word <= mem[word_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_CLEAR ? ST_CLEAR : ST_READY;
      clr_ptr   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ld_ok     <= 1'b0;
      lane_q    <= '0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) state <= ST_READY;
        end
        default: state <= ST_READY;
      endcase
      rsp_valid <= accept;
      // Response metadata only moves on accept so the last response stays visible.
      if (accept) begin
        rsp_err <= err;
        ld_ok   <= !err && !req_we;
        lane_q  <= lane;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
      end
    end
  end

  data_memory_be_extend #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANE_W    (LANE_W)
  ) u_extend (
    .word       (rd_word),
    .lane       (lane_q),
    .size       (size_q),
    .is_unsigned(uns_q),
    .data       (ext_data)
  );

  assign rsp_rdata = ld_ok ? ext_data : '0;

endmodule

// File: tb/tb_data_memory_be.sv
// tb/tb_data_memory_be.sv - directed bench: 32-bit cleared instance and 64-bit uncleared instance
module tb_data_memory_be;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_we = 1'b0, a_uns = 1'b0;
  logic [1:0]  a_size = 2'd0;
  logic [5:0]  a_addr = 6'd0;
  logic [31:0] a_wdata = 32'd0;
  logic        a_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_valid = 1'b0, b_we = 1'b0, b_uns = 1'b0;
  logic [1:0]  b_size = 2'd0;
  logic [5:0]  b_addr = 6'd0;
  logic [63:0] b_wdata = 64'd0;
  logic        b_ready, b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  data_memory_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .INIT_CLEAR(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_memory_be #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .INIT_CLEAR(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op_a(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [5:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk);
    a_we = we; a_size = sz; a_uns = uns; a_addr = addr; a_wdata = wd; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    chk({tag, ".vld"}, 64'(a_rsp_valid), 64'd1);
    chk({tag, ".err"}, 64'(a_rsp_err), 64'(exp_err));
    chk({tag, ".data"}, 64'(a_rsp_rdata), 64'(exp_data));
  endtask

  task automatic op_b(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [5:0] addr, input logic [63:0] wd,
                      input logic [63:0] exp_data, input logic exp_err);
    @(negedge clk);
    b_we = we; b_size = sz; b_uns = uns; b_addr = addr; b_wdata = wd; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    chk({tag, ".vld"}, 64'(b_rsp_valid), 64'd1);
    chk({tag, ".err"}, 64'(b_rsp_err), 64'(exp_err));
    chk({tag, ".data"}, b_rsp_rdata, exp_data);
  endtask

  task automatic wait_ready_a(input string tag, input int exp);
    int c;
    c = 0;
    while (c < 100) begin
      @(posedge clk);
      #1;
      c++;
      if (a_ready) break;
    end
    chk(tag, 64'(c), 64'(exp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.a_ready", 64'(a_ready), 64'd0);
    chk("rst.b_ready", 64'(b_ready), 64'd0);
    chk("rst.rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("rst.rsp_rdata", 64'(a_rsp_rdata), 64'd0);
    chk("rst.rsp_err", 64'(a_rsp_err), 64'd0);

    rst = 1'b0;
    #1;
    chk("b.ready_first_cycle", 64'(b_ready), 64'd1);
    chk("a.not_ready_clearing", 64'(a_ready), 64'd0);
    wait_ready_a("a.clear_cycles", 16);

    op_b("b.sd08", 1'b1, 2'd3, 1'b0, 6'h08, 64'h0123456789ABCDEF, 64'd0, 1'b0);
    op_b("b.ld08", 1'b0, 2'd3, 1'b0, 6'h08, 64'd0, 64'h0123456789ABCDEF, 1'b0);
    op_b("b.lw0c", 1'b0, 2'd2, 1'b0, 6'h0C, 64'd0, 64'h0000000001234567, 1'b0);
    op_b("b.lw08", 1'b0, 2'd2, 1'b0, 6'h08, 64'd0, 64'hFFFFFFFF89ABCDEF, 1'b0);
    op_b("b.sd0c_mis", 1'b1, 2'd3, 1'b0, 6'h0C, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
    op_b("b.ld08_again", 1'b0, 2'd3, 1'b0, 6'h08, 64'd0, 64'h0123456789ABCDEF, 1'b0);

    op_a("lw3c_cleared", 1'b0, 2'd2, 1'b0, 6'h3C, 32'd0, 32'd0, 1'b0);

    op_a("sw10", 1'b1, 2'd2, 1'b0, 6'h10, 32'h80FF7F01, 32'd0, 1'b0);
    op_a("lb10", 1'b0, 2'd0, 1'b0, 6'h10, 32'd0, 32'h00000001, 1'b0);
    op_a("lb11", 1'b0, 2'd0, 1'b0, 6'h11, 32'd0, 32'h0000007F, 1'b0);
    op_a("lbu12", 1'b0, 2'd0, 1'b1, 6'h12, 32'd0, 32'h000000FF, 1'b0);
    op_a("lb13", 1'b0, 2'd0, 1'b0, 6'h13, 32'd0, 32'hFFFFFF80, 1'b0);
    op_a("lh12", 1'b0, 2'd1, 1'b0, 6'h12, 32'd0, 32'hFFFF80FF, 1'b0);
    op_a("lhu12", 1'b0, 2'd1, 1'b1, 6'h12, 32'd0, 32'h000080FF, 1'b0);
    op_a("lw10", 1'b0, 2'd2, 1'b0, 6'h10, 32'd0, 32'h80FF7F01, 1'b0);

    op_a("sw20", 1'b1, 2'd2, 1'b0, 6'h20, 32'h11223344, 32'd0, 1'b0);
    op_a("sb21", 1'b1, 2'd0, 1'b0, 6'h21, 32'hDEADBEAA, 32'd0, 1'b0);
    op_a("sh22", 1'b1, 2'd1, 1'b0, 6'h22, 32'h1234BEEF, 32'd0, 1'b0);
    op_a("lw20", 1'b0, 2'd2, 1'b0, 6'h20, 32'd0, 32'hBEEFAA44, 1'b0);

    op_a("sw04", 1'b1, 2'd2, 1'b0, 6'h04, 32'h55667788, 32'd0, 1'b0);
    op_a("sh05_mis", 1'b1, 2'd1, 1'b0, 6'h05, 32'hFFFFFFFF, 32'd0, 1'b1);
    op_a("sw06_mis", 1'b1, 2'd2, 1'b0, 6'h06, 32'hFFFFFFFF, 32'd0, 1'b1);
    op_a("lw06_mis", 1'b0, 2'd2, 1'b0, 6'h06, 32'd0, 32'd0, 1'b1);
    op_a("lw04", 1'b0, 2'd2, 1'b0, 6'h04, 32'd0, 32'h55667788, 1'b0);

    op_a("sw08", 1'b1, 2'd2, 1'b0, 6'h08, 32'hCAFEF00D, 32'd0, 1'b0);
    op_a("sd08_illegal", 1'b1, 2'd3, 1'b0, 6'h08, 32'hFFFFFFFF, 32'd0, 1'b1);
    op_a("ld08_illegal", 1'b0, 2'd3, 1'b0, 6'h08, 32'd0, 32'd0, 1'b1);
    op_a("lw08", 1'b0, 2'd2, 1'b0, 6'h08, 32'd0, 32'hCAFEF00D, 1'b0);

    @(negedge clk);
    a_we = 1'b1; a_size = 2'd2; a_uns = 1'b0; a_addr = 6'h30; a_wdata = 32'h0BADBEEF; a_valid = 1'b1;
    @(negedge clk);
    chk("b2b.st_vld", 64'(a_rsp_valid), 64'd1);
    chk("b2b.st_err", 64'(a_rsp_err), 64'd0);
    a_we = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    chk("b2b.ld_vld", 64'(a_rsp_valid), 64'd1);
    chk("b2b.ld_data", 64'(a_rsp_rdata), 64'h0BADBEEF);
    @(negedge clk);
    chk("b2b.vld_one_cycle", 64'(a_rsp_valid), 64'd0);
    chk("b2b.data_held", 64'(a_rsp_rdata), 64'h0BADBEEF);

    @(negedge clk);
    a_we = 1'b0; a_size = 2'd2; a_addr = 6'h30; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    chk("rstmid.pending_vld", 64'(a_rsp_valid), 64'd1);
    @(negedge clk);
    chk("rstmid.vld_dropped", 64'(a_rsp_valid), 64'd0);
    chk("rstmid.rdata_zero", 64'(a_rsp_rdata), 64'd0);
    chk("rstmid.ready_low", 64'(a_ready), 64'd0);

    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready_a("rstmid.clear_restart", 16);
    op_a("lw30_cleared", 1'b0, 2'd2, 1'b0, 6'h30, 32'd0, 32'd0, 1'b0);
    op_a("lw10_cleared", 1'b0, 2'd2, 1'b0, 6'h10, 32'd0, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
